// File: rtl/gate_resp_misr.sv
// rtl/gate_resp_misr.sv - MISR response compactor with golden-signature pass/fail check
// Optional MISR_X_MASK_EN adds resp_xmask_i so masked response bits are not compacted.
module gate_resp_misr #(
  parameter int               RESP_W = 10,
  parameter int               SIG_W  = 16,
  parameter logic [SIG_W-1:0] POLY   = 16'h1021,
  parameter logic [SIG_W-1:0] SEED   = 16'h0000,
  parameter int               CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [CNT_W-1:0]  num_vectors_i,
  input  logic [SIG_W-1:0]  golden_i,
  input  logic              resp_valid_i,
  input  logic [RESP_W-1:0] resp_data_i,
`ifdef MISR_X_MASK_EN
  input  logic [RESP_W-1:0] resp_xmask_i,
`endif
  output logic              resp_ready_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [SIG_W-1:0]  signature_o,
  output logic [CNT_W-1:0]  vec_count_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q;
  logic [SIG_W-1:0]  sig_q;
  logic [SIG_W-1:0]  sig_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [CNT_W-1:0]  nvec_q;
  logic [SIG_W-1:0]  golden_q;
  logic              pass_q;
  logic              done_q;
  logic              busy_q;
  logic              ready_q;
  logic [RESP_W-1:0] resp_m;
  logic              xfer;

`ifdef MISR_X_MASK_EN
  assign resp_m = resp_data_i & ~resp_xmask_i;
`else
  assign resp_m = resp_data_i;
`endif

  assign xfer  = resp_valid_i & ready_q;
  assign cnt_d = cnt_q + CNT_W'(1);

  // Galois shift: feedback applied when the bit shifted out is 1, then the vector is folded in.
  assign sig_d = {sig_q[SIG_W-2:0], 1'b0}
               ^ (sig_q[SIG_W-1] ? POLY : {SIG_W{1'b0}})
               ^ SIG_W'(resp_m);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      sig_q    <= SEED;
      cnt_q    <= '0;
      nvec_q   <= '0;
      golden_q <= '0;
      pass_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            nvec_q   <= num_vectors_i;
            golden_q <= golden_i;
            sig_q    <= SEED;
            cnt_q    <= '0;
            pass_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b1;
            if (num_vectors_i == '0) begin
              state_q <= S_CHECK;
              ready_q <= 1'b0;
            end else begin
              state_q <= S_RUN;
              ready_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (abort_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end else if (xfer) begin
            sig_q <= sig_d;
            cnt_q <= cnt_d;
            if (cnt_d == nvec_q) begin
              state_q <= S_CHECK;
              ready_q <= 1'b0;
            end
          end
        end
        S_CHECK: begin
          busy_q <= 1'b0;
          if (abort_i) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end else begin
            state_q <= S_DONE;
            pass_q  <= (sig_q == golden_q);
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign resp_ready_o = ready_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign pass_o       = pass_q;
  assign signature_o  = sig_q;
  assign vec_count_o  = cnt_q;

endmodule

// File: tb/tb_gate_resp_misr.sv
// tb/tb_gate_resp_misr.sv - scoreboard bench for gate_resp_misr (default SEED and SEED=16'h8000 instances)
module tb_gate_resp_misr;

  typedef struct {
    logic [15:0] sig;
    logic        pass;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start8 = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] num_vectors = '0;
  logic [15:0] golden = '0;
  logic        resp_valid = 1'b0;
  logic [9:0]  resp_data = '0;
  logic [9:0]  resp_xmask = '0;

  logic        ready0, busy0, done0, pass0;
  logic [15:0] sig0, cnt0;
  logic        ready8, busy8, done8, pass8;
  logic [15:0] sig8, cnt8;

  int   errors = 0;
  int   checks = 0;
  exp_t q0[$];
  exp_t q8[$];
  logic done0_prev = 1'b0;
  logic done8_prev = 1'b0;

  always #5 clk = ~clk;

  gate_resp_misr u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .num_vectors_i(num_vectors), .golden_i(golden),
    .resp_valid_i(resp_valid), .resp_data_i(resp_data),
`ifdef MISR_X_MASK_EN
    .resp_xmask_i(resp_xmask),
`endif
    .resp_ready_o(ready0), .busy_o(busy0), .done_o(done0), .pass_o(pass0),
    .signature_o(sig0), .vec_count_o(cnt0)
  );

  gate_resp_misr #(.SEED(16'h8000)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start8), .abort_i(abort),
    .num_vectors_i(num_vectors), .golden_i(golden),
    .resp_valid_i(resp_valid), .resp_data_i(resp_data),
`ifdef MISR_X_MASK_EN
    .resp_xmask_i(resp_xmask),
`endif
    .resp_ready_o(ready8), .busy_o(busy8), .done_o(done8), .pass_o(pass8),
    .signature_o(sig8), .vec_count_o(cnt8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: each rising done pops the oldest expectation for that instance.
  always @(negedge clk) begin
    if (!rst && done0 && !done0_prev) begin
      if (q0.size() == 0) chk("dut0_unexpected_done", 32'(done0), 32'd0);
      else begin
        exp_t e;
        e = q0.pop_front();
        chk("dut0_signature", 32'(sig0), 32'(e.sig));
        chk("dut0_pass", 32'(pass0), 32'(e.pass));
        chk("dut0_vec_count", 32'(cnt0), 32'(e.cnt));
      end
    end
    if (!rst && done8 && !done8_prev) begin
      if (q8.size() == 0) chk("dut8_unexpected_done", 32'(done8), 32'd0);
      else begin
        exp_t e;
        e = q8.pop_front();
        chk("dut8_signature", 32'(sig8), 32'(e.sig));
        chk("dut8_pass", 32'(pass8), 32'(e.pass));
        chk("dut8_vec_count", 32'(cnt8), 32'(e.cnt));
      end
    end
    done0_prev = done0;
    done8_prev = done8;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect0(input logic [15:0] s, input logic p, input logic [15:0] c);
    exp_t e;
    e.sig = s; e.pass = p; e.cnt = c;
    q0.push_back(e);
  endtask

  task automatic start_run(input logic [15:0] n, input logic [15:0] g);
    num_vectors = n;
    golden      = g;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic send(input logic [9:0] d);
    resp_valid = 1'b1;
    resp_data  = d;
    tick();
    resp_valid = 1'b0;
  endtask

  task automatic wait_done0(input string name);
    int n;
    n = 0;
    while (!done0 && n < 20) begin
      tick();
      n++;
    end
    chk(name, 32'(done0), 32'd1);
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("reset_signature", 32'(sig0), 32'h0);
    chk("reset_vec_count", 32'(cnt0), 32'h0);
    chk("reset_ready", 32'(ready0), 32'd0);
    chk("reset_busy", 32'(busy0), 32'd0);
    chk("reset_done", 32'(done0), 32'd0);
    chk("reset_pass", 32'(pass0), 32'd0);
    chk("reset_seed8", 32'(sig8), 32'h8000);

    // Single all-ones vector.
    expect0(16'h03FF, 1'b1, 16'd1);
    start_run(16'd1, 16'h03FF);
    chk("t1_ready_run", 32'(ready0), 32'd1);
    chk("t1_busy_run", 32'(busy0), 32'd1);
    send(10'h3FF);
    chk("t1_ready_drop", 32'(ready0), 32'd0);
    chk("t1_check_busy", 32'(busy0), 32'd1);
    chk("t1_check_done", 32'(done0), 32'd0);
    tick();
    chk("t1_done", 32'(done0), 32'd1);
    chk("t1_busy_done", 32'(busy0), 32'd0);
    tick();
    tick();
    chk("t1_done_held", 32'(done0), 32'd1);
    chk("t1_sig_held", 32'(sig0), 32'h03FF);

    // Two vectors with a valid gap; start from DONE.
    expect0(16'h0003, 1'b1, 16'd2);
    start_run(16'd2, 16'h0003);
    chk("t2_restart_done_clr", 32'(done0), 32'd0);
    send(10'h001);
    chk("t2_sig_first", 32'(sig0), 32'h0001);
    tick();
    tick();
    tick();
    chk("t2_sig_gap", 32'(sig0), 32'h0001);
    chk("t2_cnt_gap", 32'(cnt0), 32'd1);
    send(10'h001);
    wait_done0("t2_done_timeout");

    // Zero-vector run goes straight to CHECK.
    expect0(16'h0000, 1'b1, 16'd0);
    resp_valid = 1'b1;
    resp_data  = 10'h155;
    start_run(16'd0, 16'h0000);
    chk("t4_ready", 32'(ready0), 32'd0);
    chk("t4_busy", 32'(busy0), 32'd1);
    tick();
    resp_valid = 1'b0;
    chk("t4_done", 32'(done0), 32'd1);

    // Abort after two of five vectors.
    start_run(16'd5, 16'h0000);
    send(10'h001);
    send(10'h002);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_busy", 32'(busy0), 32'd0);
    chk("t5_done", 32'(done0), 32'd0);
    chk("t5_ready", 32'(ready0), 32'd0);
    chk("t5_cnt_kept", 32'(cnt0), 32'd2);
    chk("t5_sig_kept", 32'(sig0), 32'h0000);
    expect0(16'h0155, 1'b0, 16'd1);
    start_run(16'd1, 16'h0000);
    chk("t5_restart_cnt", 32'(cnt0), 32'd0);
    // start inside RUN must be ignored
    start = 1'b1;
    num_vectors = 16'd0;
    tick();
    start = 1'b0;
    chk("t5_start_ignored", 32'(ready0), 32'd1);
    send(10'h155);
    wait_done0("t5_done_timeout");

    // Reset mid-run overrides everything.
    start_run(16'd3, 16'h0000);
    send(10'h0AA);
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    chk("rst_mid_busy", 32'(busy0), 32'd0);
    chk("rst_mid_sig", 32'(sig0), 32'h0);
    chk("rst_mid_cnt", 32'(cnt0), 32'd0);

    // Seeded instance: MSB set forces feedback on a zero vector.
    begin
      exp_t e;
      e.sig = 16'h1021; e.pass = 1'b0; e.cnt = 16'd1;
      q8.push_back(e);
    end
    num_vectors = 16'd1;
    golden      = 16'h0000;
    start8      = 1'b1;
    tick();
    start8      = 1'b0;
    chk("t3_sig_seed", 32'(sig8), 32'h8000);
    send(10'h000);
    tick();
    chk("t3_done", 32'(done8), 32'd1);

`ifdef MISR_X_MASK_EN
    expect0(16'h000F, 1'b1, 16'd1);
    start_run(16'd1, 16'h000F);
    resp_xmask = 10'h3F0;
    send(10'h3FF);
    resp_xmask = 10'h000;
    wait_done0("t6_done_timeout");
`endif

    tick();
    tick();
    chk("scoreboard0_drained", 32'(q0.size()), 32'd0);
    chk("scoreboard8_drained", 32'(q8.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
